instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Upstream fetch stage of the MIPS core; owns the program counter and the instruction register.
- Fetches one 32-bit word from instruction memory using a req/ready handshake. Holds it on instr_o and opcode_o for the decode/control stage until consumed, then computes the next PC.
- Next PC is PC+4 or the beq/bne branch target, using the control unit's branch flags and the ALU zero flag.

Parameters:
- PC_RESET, 32'h0040_0000, PC value loaded on reset (word-aligned).
- DATA_WIDTH, 32, instruction/PC width; only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-low reset
- mem_req_o  out  1  fetch request to instruction memory
- mem_addr_o  out  32  fetch address, equals pc_o
- mem_ready_i  in  1  memory accepts request; mem_rdata_i valid this cycle
- mem_rdata_i  in  32  instruction word
- instr_o  out  32  held instruction
- opcode_o  out  6  instr_o[31:26], to control unit
- instr_valid_o  out  1  instr_o is valid for decode/execute
- instr_ready_i  in  1  execute consumes instruction this cycle
- branch_eq_i  in  1  beq flag from control
- branch_ne_i  in  1  bne flag from control
- zero_i  in  1  ALU zero flag
- imm_ext_i  in  32  sign-extended 16-bit immediate
- pc_o  out  32  address of current instruction
- pc_plus4_o  out  32  pc_o + 4, combinational
- retired_cnt_o  out  32  count of consumed instructions

Behaviour:
- Reset, sampled on clk while reset==0, sets:
  - pc_o=PC_RESET, instr_o=0, instr_valid_o=0, mem_req_o=0, retired_cnt_o=0, state=IDLE.
- States and transitions:
  - IDLE: entered from reset. Goes to FETCH on the next clk after reset returns to 1.
  - FETCH: mem_req_o=1, mem_addr_o=pc_o.
    - mem_ready_i=1: capture mem_rdata_i into instr_o and go to EXEC.
    - Otherwise stay in FETCH. Request and address stay stable while waiting.
  - EXEC: mem_req_o=0, instr_valid_o=1.
    - instr_ready_i=1 (handshake): update PC, increment retired_cnt_o, clear instr_valid_o, go to FETCH.
    - Otherwise hold all outputs.
- Latency: zero-wait memory gives 2 cycles per instruction (1 FETCH + 1 EXEC). Each memory wait state adds 1 cycle.
- Next PC, evaluated only on the handshake cycle:
  - taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i).
  - next_pc = taken ? pc_plus4 + (imm_ext_i << 2) : pc_plus4.
- Width and boundary rules:
  - All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
  - pc_o[1:0] is always 2'b00.
  - branch_eq_i and branch_ne_i both high: taken is still the OR above (no error).
- Inputs ignored outside their states:
  - mem_ready_i outside FETCH.
  - instr_ready_i outside EXEC.
  - Branch inputs outside the handshake cycle.
- Reset mid-operation (FETCH waiting, or EXEC) returns to reset values next edge. Any pending memory response is discarded; mem_req_o drops in the same edge.
- retired_cnt_o wraps from 32'hFFFF_FFFF to 0.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants: R_TYPE=6'h00, ADDI=6'h08, ANDI=6'h0C, ORI=6'h0D, LUI=6'h0F, BEQ=6'h04, BNE=6'h05.
  - PC_RESET default.
  - Fetch state encoding {IDLE, FETCH, EXEC}.
- One sub-module: pc_register. Parameterised-width register with synchronous active-low reset to a parameter value and a load enable. Used for the PC; the instruction register reuses it with reset value 0.

Test Plan:
- Reset held 3 cycles, then released -> pc_o=32'h0040_0000, instr_valid_o=0, mem_req_o=0 during reset. mem_req_o=1 with mem_addr_o=32'h0040_0000 on the 2nd cycle after release.
- Zero-wait memory, instr_ready_i=1, branches low, 4 instructions -> addresses 0x00400000/04/08/0C. instr_valid_o pulses every 2nd cycle; retired_cnt_o=4.
- mem_ready_i low for 3 cycles in FETCH -> mem_req_o and mem_addr_o stable for 4 cycles, then instr_o=mem_rdata_i (e.g. 32'h2008_0005) and opcode_o=6'h08.
- pc=0x00400010, branch_eq_i=1, zero_i=1, imm_ext_i=32'h0000_0003 -> next mem_addr_o=0x00400020. Same with zero_i=0 -> 0x00400014.
- branch_ne_i=1, zero_i=0, imm_ext_i=32'hFFFF_FFFC at pc=0x00400010 -> next address 0x00400004. instr_ready_i low for 5 cycles before this -> instr_o held and PC unchanged until the handshake.
- reset asserted while in FETCH waiting -> next edge mem_req_o=0, pc_o=PC_RESET, retired_cnt_o=0. A late mem_ready_i is ignored. Separately, force pc=0xFFFFFFFC with no branch -> next fetch address 0x00000000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, fetch-stage state encoding and
// the branch helpers used by the instruction fetch stage.
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] LUI    = 6'h0F;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_e;

    function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

    // Word offset is scaled by 4; all arithmetic wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc_plus4,
                                            input logic [31:0] imm_ext,
                                            input logic        taken);
        logic [31:0] target;
        target = pc_plus4 + (imm_ext << 2);
        return taken ? target : pc_plus4;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Width-parameterised register with synchronous active-low reset to a
// fixed value and a load enable; holds the PC and the instruction word.
module pc_register #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q <= RESET_VAL;
        end else if (load_i) begin
            value_q <= d_i;
        end
    end

    assign q_o = value_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns PC and instruction register, fetches one word per
// instruction over a req/ready handshake and selects PC+4 or branch target.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [5:0]            opcode_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    input  logic                  branch_eq_i,
    input  logic                  branch_ne_i,
    input  logic                  zero_i,
    input  logic [DATA_WIDTH-1:0] imm_ext_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic [31:0]           retired_cnt_o
);

    fetch_state_e          state_q;
    logic                  mem_req_q;
    logic                  instr_valid_q;
    logic [31:0]           retired_cnt_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_plus4_s;
    logic                  taken_s;
    logic                  pc_load_s;
    logic                  instr_load_s;

    assign pc_plus4_s   = pc_q + 32'd4;
    assign taken_s      = branch_taken(branch_eq_i, branch_ne_i, zero_i);
    assign pc_load_s    = (state_q == EXEC) && instr_ready_i;
    assign instr_load_s = (state_q == FETCH) && mem_ready_i;

    // Low PC bits are forced clear so the PC stays word-aligned whatever the immediate.
    always_comb begin
        pc_d = next_pc(pc_plus4_s, imm_ext_i, taken_s) & ~32'd3;
    end

    pc_register #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .load_i (pc_load_s),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    pc_register #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL ({DATA_WIDTH{1'b0}})
    ) u_instr_reg (
        .clk    (clk),
        .reset  (reset),
        .load_i (instr_load_s),
        .d_i    (mem_rdata_i),
        .q_o    (instr_q)
    );

    // Fetch sequencing; request and valid are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            retired_cnt_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q   <= FETCH;
                    mem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (mem_ready_i) begin
                        state_q       <= EXEC;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (instr_ready_i) begin
                        state_q       <= FETCH;
                        mem_req_q     <= 1'b1;
                        instr_valid_q <= 1'b0;
                        retired_cnt_q <= retired_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = pc_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4_s;
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[31:26];
    assign instr_valid_o = instr_valid_q;
    assign retired_cnt_o = retired_cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expected fetch
// addresses and instruction words, a negedge monitor checks them on handshakes.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic [5:0]  opcode_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        branch_eq_i;
    logic        branch_ne_i;
    logic        zero_i;
    logic [31:0] imm_ext_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] retired_cnt_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];
    logic [5:0]  opc_q[$];

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ready_i   (mem_ready_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_o       (instr_o),
        .opcode_o      (opcode_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .branch_eq_i   (branch_eq_i),
        .branch_ne_i   (branch_ne_i),
        .zero_i        (zero_i),
        .imm_ext_i     (imm_ext_i),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .retired_cnt_o (retired_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: fetch handshakes pop addresses, execute handshakes pop instructions.
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_req_o === 1'b1 && mem_ready_i === 1'b1) begin
            if (addr_q.size() == 0) begin
                check("sb_unexpected_fetch", mem_addr_o, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] ea;
                ea = addr_q.pop_front();
                check("sb_fetch_addr", mem_addr_o, ea);
                check("sb_pc", pc_o, ea);
                check("sb_pc_plus4", pc_plus4_o, ea + 32'd4);
            end
        end
        if (reset === 1'b1 && instr_valid_o === 1'b1 && instr_ready_i === 1'b1) begin
            if (instr_q.size() == 0) begin
                check("sb_unexpected_exec", instr_o, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] ei;
                logic [5:0]  eo;
                ei = instr_q.pop_front();
                eo = opc_q.pop_front();
                check("sb_instr", instr_o, ei);
                check("sb_opcode", {26'd0, opcode_o}, {26'd0, eo});
            end
        end
    end

    // One fetch/execute round trip; DUT is expected to be in FETCH on entry.
    task automatic do_instr(input logic [31:0] addr, input logic [31:0] word, input logic [5:0] opc,
                            input int waits, input int holds,
                            input logic beq, input logic bne, input logic z, input logic [31:0] imm);
        addr_q.push_back(addr);
        instr_q.push_back(word);
        opc_q.push_back(opc);
        check("fetch_req", mem_req_o, 1'b1);
        check("fetch_addr", mem_addr_o, addr);
        for (int i = 0; i < waits; i++) begin
            mem_ready_i = 1'b0;
            mem_rdata_i = 32'hDEAD_BEEF;
            step();
            check("wait_req", mem_req_o, 1'b1);
            check("wait_addr", mem_addr_o, addr);
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = word;
        step();
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h0;
        check("valid_rise", instr_valid_o, 1'b1);
        check("req_drop", mem_req_o, 1'b0);
        for (int i = 0; i < holds; i++) begin
            instr_ready_i = 1'b0;
            branch_eq_i   = 1'b1;
            branch_ne_i   = 1'b0;
            zero_i        = 1'b1;
            imm_ext_i     = 32'h0000_0100;
            mem_ready_i   = 1'b1;
            mem_rdata_i   = ~word;
            step();
            check("hold_instr", instr_o, word);
            check("hold_pc", pc_o, addr);
            check("hold_valid", instr_valid_o, 1'b1);
        end
        mem_ready_i   = 1'b0;
        instr_ready_i = 1'b1;
        branch_eq_i   = beq;
        branch_ne_i   = bne;
        zero_i        = z;
        imm_ext_i     = imm;
        step();
        instr_ready_i = 1'b0;
        branch_eq_i   = 1'b0;
        branch_ne_i   = 1'b0;
        zero_i        = 1'b0;
        imm_ext_i     = 32'h0;
        check("valid_fall", instr_valid_o, 1'b0);
        check("req_rise", mem_req_o, 1'b1);
    endtask

    initial begin
        reset         = 1'b0;
        mem_ready_i   = 1'b0;
        mem_rdata_i   = 32'h0;
        instr_ready_i = 1'b0;
        branch_eq_i   = 1'b0;
        branch_ne_i   = 1'b0;
        zero_i        = 1'b0;
        imm_ext_i     = 32'h0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_pc", pc_o, 32'h0040_0000);
            check("rst_req", mem_req_o, 1'b0);
            check("rst_valid", instr_valid_o, 1'b0);
        end
        check("rst_instr", instr_o, 32'h0);
        check("rst_cnt", retired_cnt_o, 32'h0);
        reset = 1'b1;
        check("idle_req", mem_req_o, 1'b0);
        step();
        check("first_req", mem_req_o, 1'b1);
        check("first_addr", mem_addr_o, 32'h0040_0000);

        // Sequential, zero-wait fetches.
        do_instr(32'h0040_0000, 32'h012A_4020, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_instr(32'h0040_0004, 32'h3508_00FF, 6'h0D, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_instr(32'h0040_0008, 32'h3129_000F, 6'h0C, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        do_instr(32'h0040_000C, 32'h3C01_1234, 6'h0F, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("cnt_after4", retired_cnt_o, 32'd4);

        // Wait states, then branches.
        do_instr(32'h0040_0010, 32'h2008_0005, 6'h08, 3, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0003);
        do_instr(32'h0040_0020, 32'h1000_FFFB, 6'h04, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFB);
        do_instr(32'h0040_0010, 32'h1000_0003, 6'h04, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0003);
        do_instr(32'h0040_0014, 32'h1400_FFFE, 6'h05, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
        do_instr(32'h0040_0010, 32'h1400_FFFC, 6'h05, 0, 5, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        do_instr(32'h0040_0004, 32'h1000_0001, 6'h04, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0001);
        do_instr(32'h0040_000C, 32'h1000_FFFB, 6'h04, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFEF_FFFB);
        do_instr(32'hFFFF_FFFC, 32'h0000_0000, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", mem_addr_o, 32'h0000_0000);
        check("cnt_after12", retired_cnt_o, 32'd12);

        // Reset while a fetch is waiting; the late response must be dropped.
        step();
        check("pre_rst_addr", mem_addr_o, 32'h0000_0000);
        reset       = 1'b0;
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'hBAD0_BAD0;
        step();
        check("midrst_req", mem_req_o, 1'b0);
        check("midrst_pc", pc_o, 32'h0040_0000);
        check("midrst_cnt", retired_cnt_o, 32'd0);
        check("midrst_valid", instr_valid_o, 1'b0);
        check("midrst_instr", instr_o, 32'h0);
        reset = 1'b1;
        step();
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h0;
        check("late_ready_valid", instr_valid_o, 1'b0);
        check("late_ready_instr", instr_o, 32'h0);
        check("late_ready_req", mem_req_o, 1'b1);

        do_instr(32'h0040_0000, 32'h2009_0001, 6'h08, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("recover_addr", mem_addr_o, 32'h0040_0004);
        check("recover_cnt", retired_cnt_o, 32'd1);
        step();
        check("sb_addr_drained", addr_q.size(), 32'd0);
        check("sb_instr_drained", instr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
